// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: takes a WIDTH-bit word over valid/ready and
// emits it one bit per clock on data_out/data_valid, with an optional idle gap.
module piso_serializer #(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] par_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [7:0]    GAP_LAST = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;

  logic load_ready_q, load_ready_d;
  logic data_out_q, data_out_d;
  logic data_valid_q, data_valid_d;
  logic busy_q, busy_d;
  logic word_done_q, word_done_d;

  logic             accept;
  logic [WIDTH-1:0] shift_next;

  // Handshake is qualified by the registered ready the upstream actually saw.
  assign accept     = load_valid && load_ready_q;
  assign shift_next = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                : {1'b0, shift_q[WIDTH-1:1]};

  // State register: every flop is cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from pre-edge values.
    if (reset) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      load_ready_q <= 1'b0;
      data_out_q   <= 1'b0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      word_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      load_ready_q <= load_ready_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      word_done_q  <= word_done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_SHIFT;
          shift_d   = par_in;
          bit_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q != BIT_LAST) begin
          shift_d   = shift_next;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end else if (GAP_CYCLES > 0) begin
          state_d   = ST_GAP;
          shift_d   = '0;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
        end else if (accept) begin
          shift_d   = par_in;
          bit_cnt_d = '0;
        end else begin
          state_d   = ST_IDLE;
          shift_d   = '0;
          bit_cnt_d = '0;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next state so they are registered yet aligned.
  always_comb begin
    data_valid_d = (state_d == ST_SHIFT);
    busy_d       = (state_d != ST_IDLE);
    word_done_d  = (state_d == ST_SHIFT) && (bit_cnt_d == BIT_LAST);
    load_ready_d = (state_d == ST_IDLE) ||
                   ((GAP_CYCLES == 0) && word_done_d);
    data_out_d   = 1'b0;
    if (data_valid_d) begin
      data_out_d = MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0];
    end
  end

  assign load_ready = load_ready_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign word_done  = word_done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: three instances cover back-to-back MSB-first,
// two-cycle gap, and LSB-first configurations; outputs sampled 1ns after clk.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] par_in;
  logic       load_valid;

  logic [2:0] load_ready, data_out, data_valid, busy, word_done;
  logic [3:0] sipo_q;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_msb_gap0 (
    .clk(clk), .reset(reset), .par_in(par_in), .load_valid(load_valid),
    .load_ready(load_ready[0]), .data_out(data_out[0]), .data_valid(data_valid[0]),
    .busy(busy[0]), .word_done(word_done[0]));

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) u_msb_gap2 (
    .clk(clk), .reset(reset), .par_in(par_in), .load_valid(load_valid),
    .load_ready(load_ready[1]), .data_out(data_out[1]), .data_valid(data_valid[1]),
    .busy(busy[1]), .word_done(word_done[1]));

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) u_lsb_gap0 (
    .clk(clk), .reset(reset), .par_in(par_in), .load_valid(load_valid),
    .load_ready(load_ready[2]), .data_out(data_out[2]), .data_valid(data_valid[2]),
    .busy(busy[2]), .word_done(word_done[2]));

  // Model of the downstream 4-bit SIPO fed by the MSB-first instance.
  always @(posedge clk) begin
    if (reset)              sipo_q <= 4'b0000;
    else if (data_valid[0]) sipo_q <= {sipo_q[2:0], data_out[0]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // e = {data_valid, data_out, word_done, busy, load_ready}
  task automatic check_outs(input string tag, input int u, input logic [4:0] e);
    check({tag, ".data_valid"}, 32'(data_valid[u]), 32'(e[4]));
    check({tag, ".data_out"},   32'(data_out[u]),   32'(e[3]));
    check({tag, ".word_done"},  32'(word_done[u]),  32'(e[2]));
    check({tag, ".busy"},       32'(busy[u]),       32'(e[1]));
    check({tag, ".load_ready"}, 32'(load_ready[u]), 32'(e[0]));
  endtask

  task automatic row(input string tag, input int u, input logic [4:0] e);
    step();
    check_outs(tag, u, e);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    load_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    reset      = 1'b1;
    load_valid = 1'b1;
    par_in     = 4'b1011;

    // Reset held two cycles with load_valid high: reset wins, all outputs low.
    step();
    step();
    for (int u = 0; u < 3; u++) check_outs($sformatf("t1_rst_u%0d", u), u, 5'b00000);
    reset      = 1'b0;
    load_valid = 1'b0;
    step();
    for (int u = 0; u < 3; u++) check_outs($sformatf("t1_rel_u%0d", u), u, 5'b00001);

    // MSB-first 1011 -> 1,0,1,1, word_done on 4th, SIPO captures 1011.
    par_in     = 4'b1011;
    load_valid = 1'b1;
    row("t2_b0", 0, 5'b11010);
    load_valid = 1'b0;
    row("t2_b1", 0, 5'b10010);
    row("t2_b2", 0, 5'b11010);
    row("t2_b3", 0, 5'b11111);
    row("t2_idle", 0, 5'b00001);
    check("t2_sipo", 32'(sipo_q), 32'h0000000B);

    // Back-to-back 1100 then 0011 with valid held: 8 contiguous bits.
    do_reset();
    par_in     = 4'b1100;
    load_valid = 1'b1;
    row("t3_b0", 0, 5'b11010);
    par_in = 4'b0011;
    row("t3_b1", 0, 5'b11010);
    row("t3_b2", 0, 5'b10010);
    row("t3_b3", 0, 5'b10111);
    row("t3_b4", 0, 5'b10010);
    load_valid = 1'b0;
    row("t3_b5", 0, 5'b10010);
    row("t3_b6", 0, 5'b11010);
    row("t3_b7", 0, 5'b11111);
    row("t3_idle", 0, 5'b00001);

    // Two-cycle gap: load_valid held through gap is ignored until IDLE.
    do_reset();
    par_in     = 4'b1010;
    load_valid = 1'b1;
    row("t4_w0b0", 1, 5'b11010);
    par_in = 4'b0101;
    row("t4_w0b1", 1, 5'b10010);
    row("t4_w0b2", 1, 5'b11010);
    row("t4_w0b3", 1, 5'b10110);
    row("t4_gap0", 1, 5'b00010);
    row("t4_gap1", 1, 5'b00010);
    row("t4_idle", 1, 5'b00001);
    row("t4_w1b0", 1, 5'b10010);
    load_valid = 1'b0;
    row("t4_w1b1", 1, 5'b11010);
    row("t4_w1b2", 1, 5'b10010);
    row("t4_w1b3", 1, 5'b11110);
    row("t4_gap2", 1, 5'b00010);

    // Reset after 2nd bit of 1111 aborts the word; 0110 then sent cleanly.
    do_reset();
    par_in     = 4'b1111;
    load_valid = 1'b1;
    row("t5_b0", 0, 5'b11010);
    load_valid = 1'b0;
    row("t5_b1", 0, 5'b11010);
    reset = 1'b1;
    row("t5_abort", 0, 5'b00000);
    reset = 1'b0;
    row("t5_rel", 0, 5'b00001);
    row("t5_quiet", 0, 5'b00001);
    par_in     = 4'b0110;
    load_valid = 1'b1;
    row("t5_b0n", 0, 5'b10010);
    load_valid = 1'b0;
    row("t5_b1n", 0, 5'b11010);
    row("t5_b2n", 0, 5'b11010);
    row("t5_b3n", 0, 5'b10111);
    row("t5_idle", 0, 5'b00001);

    // LSB-first 1011 -> 1,1,0,1; par_in cleared mid-word has no effect.
    do_reset();
    par_in     = 4'b1011;
    load_valid = 1'b1;
    row("t6_b0", 2, 5'b11010);
    par_in     = 4'b0000;
    load_valid = 1'b0;
    row("t6_b1", 2, 5'b11010);
    row("t6_b2", 2, 5'b10010);
    row("t6_b3", 2, 5'b11111);
    row("t6_idle", 2, 5'b00001);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
